// File: rtl/debounce_bank.sv
// debounce_bank: multi-channel input conditioner.
// Each channel has a two-flop synchronizer and a saturating up/down counter
// with hysteresis. The block produces debounced levels, one-clk rise/fall
// pulses, sticky event flags with per-channel clear, and an any-event summary.
module debounce_bank #(
  parameter int CHANNELS   = 4,
  parameter int WIDTH      = 8,
  parameter int EVENT_MODE = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clk_enable,
  input  logic [CHANNELS-1:0] data,
  output logic [CHANNELS-1:0] debounced,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] event_flags,
  input  logic [CHANNELS-1:0] event_clear,
  output logic                any_event
);

  localparam logic [WIDTH-1:0] MAX = '1;

  logic [CHANNELS-1:0] sync_meta;
  logic [CHANNELS-1:0] sync;
  logic [WIDTH-1:0]    count      [CHANNELS];
  logic [WIDTH-1:0]    count_next [CHANNELS];
  logic [CHANNELS-1:0] deb_next;
  logic [CHANNELS-1:0] rise_next;
  logic [CHANNELS-1:0] fall_next;
  logic [CHANNELS-1:0] set_event;
  logic [CHANNELS-1:0] flags_next;

  // Next-state logic: saturating counter, hysteresis level, edges, sticky flags.
  always_comb begin
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      count_next[i] = count[i];
      deb_next[i]   = debounced[i];
      if (clk_enable) begin
        if (sync[i] && (count[i] != MAX)) begin
          count_next[i] = count[i] + 1'b1;
        end else if (!sync[i] && (count[i] != '0)) begin
          count_next[i] = count[i] - 1'b1;
        end
        if (count_next[i] == MAX) begin
          deb_next[i] = 1'b1;
        end else if (count_next[i] == '0) begin
          deb_next[i] = 1'b0;
        end
      end
    end
    rise_next = deb_next & ~debounced;
    fall_next = ~deb_next & debounced;
    case (EVENT_MODE)
      0:       set_event = rise_next;
      1:       set_event = fall_next;
      default: set_event = rise_next | fall_next;
    endcase
    // Set has priority over clear so an event coinciding with a clear survives.
    flags_next = set_event | (event_flags & ~event_clear);
  end

  // Two-flop synchronizer, clocked every cycle regardless of clk_enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta <= '0;
      sync      <= '0;
    end else begin
      sync_meta <= data;
      sync      <= sync_meta;
    end
  end

  // Per-channel saturating counters.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (reset) begin
        count[i] <= '0;
      end else begin
        count[i] <= count_next[i];
      end
    end
  end

  // Registered outputs: level, edge pulses, sticky flags and their summary.
  always_ff @(posedge clk) begin
    if (reset) begin
      debounced   <= '0;
      rise        <= '0;
      fall        <= '0;
      event_flags <= '0;
      any_event   <= 1'b0;
    end else begin
      debounced   <= deb_next;
      rise        <= rise_next;
      fall        <= fall_next;
      event_flags <= flags_next;
      any_event   <= |flags_next;
    end
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Self-checking bench for debounce_bank: two instances (event on both edges,
// and event on rise only), WIDTH=3, CHANNELS=2, against a behavioural model.
module tb_debounce_bank;

  localparam int MAXC = 7;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clk_enable = 1'b0;
  logic [1:0] data = '0;
  logic [1:0] event_clear = '0;
  logic [1:0] deb_a, rise_a, fall_a, flags_a, deb_b, rise_b, fall_b, flags_b;
  logic       any_a, any_b;

  int total = 0;
  int bad = 0;

  // Behavioural model state
  logic [1:0] m_s1 = '0, m_s2 = '0, m_deb = '0, m_rise = '0, m_fall = '0;
  logic [1:0] m_fa = '0, m_fb = '0;
  logic       m_anya = 1'b0, m_anyb = 1'b0;
  int         m_cnt [2] = '{0, 0};

  always #5 clk = ~clk;

  debounce_bank #(.CHANNELS(2), .WIDTH(3), .EVENT_MODE(2)) dut_a (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .data(data),
    .debounced(deb_a), .rise(rise_a), .fall(fall_a), .event_flags(flags_a),
    .event_clear(event_clear), .any_event(any_a));

  debounce_bank #(.CHANNELS(2), .WIDTH(3), .EVENT_MODE(0)) dut_b (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .data(data),
    .debounced(deb_b), .rise(rise_b), .fall(fall_b), .event_flags(flags_b),
    .event_clear(event_clear), .any_event(any_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clk edge given the inputs present before it.
  task automatic model_edge(input logic [1:0] d, input logic e, input logic [1:0] c, input logic r);
    logic [1:0] old_deb;
    if (r) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0; m_rise = '0; m_fall = '0;
      m_fa = '0; m_fb = '0; m_anya = 1'b0; m_anyb = 1'b0;
      m_cnt[0] = 0; m_cnt[1] = 0;
    end else begin
      old_deb = m_deb;
      for (int ch = 0; ch < 2; ch++) begin
        if (e) begin
          if (m_s2[ch]) m_cnt[ch] = (m_cnt[ch] < MAXC) ? m_cnt[ch] + 1 : MAXC;
          else          m_cnt[ch] = (m_cnt[ch] > 0) ? m_cnt[ch] - 1 : 0;
          if (m_cnt[ch] == MAXC)   m_deb[ch] = 1'b1;
          else if (m_cnt[ch] == 0) m_deb[ch] = 1'b0;
        end
      end
      m_rise = m_deb & ~old_deb;
      m_fall = ~m_deb & old_deb;
      m_fa = (m_rise | m_fall) | (m_fa & ~c);
      m_fb = m_rise | (m_fb & ~c);
      m_anya = |m_fa;
      m_anyb = |m_fb;
      m_s2 = m_s1;
      m_s1 = d;
    end
  endtask

  // Drive one cycle, update the model, then compare all outputs after the edge.
  task automatic step(input logic [1:0] d, input logic e, input logic [1:0] c, input logic r);
    data = d; clk_enable = e; event_clear = c; reset = r;
    @(posedge clk);
    model_edge(d, e, c, r);
    #1;
    chk("deb_a",   32'(deb_a),   32'(m_deb));
    chk("rise_a",  32'(rise_a),  32'(m_rise));
    chk("fall_a",  32'(fall_a),  32'(m_fall));
    chk("flags_a", 32'(flags_a), 32'(m_fa));
    chk("any_a",   32'(any_a),   32'(m_anya));
    chk("deb_b",   32'(deb_b),   32'(m_deb));
    chk("rise_b",  32'(rise_b),  32'(m_rise));
    chk("fall_b",  32'(fall_b),  32'(m_fall));
    chk("flags_b", 32'(flags_b), 32'(m_fb));
    chk("any_b",   32'(any_b),   32'(m_anyb));
  endtask

  initial begin
    int first;
    logic [1:0] d;

    // Reset held with inputs high: everything stays 0.
    for (int i = 0; i < 3; i++) step(2'b11, 1'b1, 2'b00, 1'b1);
    chk("reset_deb", 32'(deb_a), 32'd0);

    // Release: debounced[0] must rise on the 9th edge, with a one-cycle rise.
    first = 0;
    for (int n = 1; n <= 12; n++) begin
      step(2'b11, 1'b1, 2'b00, 1'b0);
      if (first == 0 && deb_a[0] === 1'b1) begin
        first = n;
        chk("rise_at_first", 32'(rise_a[0]), 32'd1);
        chk("flag_at_first", 32'(flags_a[0]), 32'd1);
        chk("any_at_first", 32'(any_a), 32'd1);
      end
    end
    chk("rise_edge", 32'(first), 32'd9);

    // Saturation: stay high, then fall after 2 sync + 7 enabled samples.
    for (int i = 0; i < 8; i++) step(2'b11, 1'b1, 2'b00, 1'b0);
    first = 0;
    for (int n = 1; n <= 12; n++) begin
      step(2'b00, 1'b1, 2'b00, 1'b0);
      if (first == 0 && deb_a[0] === 1'b0) begin
        first = n;
        chk("fall_pulse", 32'(fall_a[0]), 32'd1);
        chk("modeb_flag_hold", 32'(flags_b[0]), 32'd1);
      end
    end
    chk("fall_edge", 32'(first), 32'd9);

    // Clear all flags, then bounce rejection on channel 0.
    step(2'b00, 1'b1, 2'b11, 1'b0);
    d = 2'b00;
    for (int i = 0; i < 100; i++) begin
      d[0] = ~d[0];
      step(d, 1'b1, 2'b00, 1'b0);
    end
    chk("bounce_deb", 32'(deb_a), 32'd0);

    // Enable gating: one enabled cycle in four.
    for (int i = 0; i < 4; i++) step(2'b00, 1'b1, 2'b00, 1'b0);
    first = 0;
    for (int n = 1; n <= 40; n++) begin
      step(2'b01, (n % 4) == 0, 2'b00, 1'b0);
      if (first == 0 && deb_a[0] === 1'b1) first = n;
    end
    chk("gated_rise_edge", 32'(first), 32'd28);

    // Bring channel 0 back low, clear flags.
    for (int i = 0; i < 10; i++) step(2'b00, 1'b1, 2'b11, 1'b0);
    step(2'b00, 1'b1, 2'b11, 1'b0);
    // Clear collision on channel 1: clear coincides with the rise edge.
    for (int n = 1; n <= 9; n++) step(2'b10, 1'b1, (n == 9) ? 2'b10 : 2'b00, 1'b0);
    chk("coll_rise", 32'(rise_a[1]), 32'd1);
    chk("coll_flag", 32'(flags_a[1]), 32'd1);
    step(2'b10, 1'b1, 2'b11, 1'b0);
    chk("clear_flag", 32'(flags_a[1]), 32'd0);
    chk("clear_any", 32'(any_a), 32'd0);

    // Reset mid-operation: counter at 5 with debounced high.
    for (int i = 0; i < 10; i++) step(2'b11, 1'b1, 2'b00, 1'b0);
    for (int i = 0; i < 4; i++) step(2'b00, 1'b1, 2'b00, 1'b0);
    chk("mid_deb_pre", 32'(deb_a), 32'd3);
    step(2'b00, 1'b1, 2'b00, 1'b1);
    chk("mid_deb", 32'(deb_a), 32'd0);
    chk("mid_fall", 32'(fall_a), 32'd0);
    step(2'b00, 1'b1, 2'b00, 1'b0);
    chk("mid_fall_after", 32'(fall_a), 32'd0);

    // Randomised run: slowly varying inputs, random enables, clears, resets.
    d = 2'b00;
    for (int i = 0; i < 600; i++) begin
      for (int ch = 0; ch < 2; ch++) if ($urandom_range(0, 11) == 0) d[ch] = ~d[ch];
      step(d, $urandom_range(0, 3) != 0,
           {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)},
           $urandom_range(0, 199) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
